// File: rtl/matrix_loader_if.sv
// Host byte streams, shared-memory port and control-unit strobes of
// matrix_loader. master = loader side, slave = host/memory/control side.
interface matrix_loader_if;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic [1:0]   mem_address;
  logic [199:0] mem_data;
  logic         mem_wren;
  logic [199:0] mem_q;
  logic         mem_own;
  logic         start;
  logic         ready;
  logic         overflow;
  logic         ovf_flag;
  logic         busy;

  modport master (
    input  in_valid, in_data, out_ready,
    input  mem_q, ready, overflow,
    output in_ready, out_valid, out_data,
    output mem_address, mem_data, mem_wren, mem_own,
    output start, ovf_flag, busy
  );

  modport slave (
    output in_valid, in_data, out_ready,
    output mem_q, ready, overflow,
    input  in_ready, out_valid, out_data,
    input  mem_address, mem_data, mem_wren, mem_own,
    input  start, ovf_flag, busy
  );
endinterface

// File: rtl/matrix_loader.sv
// Host front end: packs a 52-byte frame into memory words 0..2, starts the
// coprocessor; readback of word 3 exists only with MATRIX_LOADER_READBACK_EN.
module matrix_loader #(
  parameter int unsigned RD_LAT = 1
) (
  input logic             clk_coprocessor,
  input logic             rst,
  matrix_loader_if.master bus
);

`ifdef MATRIX_LOADER_READBACK_EN
  typedef enum logic [2:0] {
    S_RECV, S_WR0, S_WR1, S_WR2,
    S_START, S_WAIT, S_RD, S_TX
  } state_e;
`else
  typedef enum logic [2:0] {
    S_RECV, S_WR0, S_WR1, S_WR2,
    S_START, S_WAIT
  } state_e;
`endif

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [7:0]   msize_q, msize_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [199:0] a_q, a_d;
  logic [199:0] b_q, b_d;
  logic         ovf_q, ovf_d;

  logic         in_ready_q, in_ready_d;
  logic [1:0]   mem_address_q, mem_address_d;
  logic [199:0] mem_data_q, mem_data_d;
  logic         mem_wren_q, mem_wren_d;
  logic         mem_own_q, mem_own_d;
  logic         start_q, start_d;
  logic         busy_q, busy_d;

  logic         in_hs;
  assign in_hs = bus.in_valid && in_ready_q;

`ifdef MATRIX_LOADER_READBACK_EN
  localparam logic [7:0] RD_LAST = RD_LAT[7:0];

  logic [7:0]   rd_cnt_q, rd_cnt_d;
  logic [4:0]   tx_cnt_q, tx_cnt_d;
  logic [199:0] sh_q, sh_d;
  logic         out_valid_q, out_valid_d;
  logic [7:0]   out_data_q, out_data_d;
  logic         out_hs;

  assign out_hs = out_valid_q && bus.out_ready;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msize_d  = msize_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    ovf_d    = ovf_q;
`ifdef MATRIX_LOADER_READBACK_EN
    rd_cnt_d   = rd_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    sh_d       = sh_q;
    out_data_d = out_data_q;
`endif

    unique case (state_q)
      S_RECV: begin
        if (in_hs) begin
          cnt_d = cnt_q + 6'd1;
          // Matrices shift in from the LSB end so byte 0 ends up at the MSB
          unique case (1'b1)
            cnt_q == 6'd0:
              msize_d = bus.in_data;
            cnt_q == 6'd1:
              opcode_d = bus.in_data;
            (cnt_q >= 6'd2) && (cnt_q <= 6'd26):
              a_d = {a_q[191:0], bus.in_data};
            cnt_q >= 6'd27:
              b_d = {b_q[191:0], bus.in_data};
            default: ;
          endcase
          if (cnt_q == 6'd51) begin
            cnt_d   = '0;
            state_d = S_WR0;
          end
        end
      end
      S_WR0:   state_d = S_WR1;
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.ready) begin
          ovf_d = bus.overflow;
`ifdef MATRIX_LOADER_READBACK_EN
          rd_cnt_d = '0;
          state_d  = S_RD;
`else
          state_d  = S_RECV;
`endif
        end
      end
`ifdef MATRIX_LOADER_READBACK_EN
      S_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          sh_d       = bus.mem_q;
          out_data_d = {7'b0, ovf_q};
          tx_cnt_d   = '0;
          state_d    = S_TX;
        end else begin
          rd_cnt_d = rd_cnt_q + 8'd1;
        end
      end
      S_TX: begin
        if (out_hs) begin
          if (tx_cnt_q == 5'd25) begin
            out_data_d = '0;
            state_d    = S_RECV;
          end else begin
            out_data_d = sh_q[199:192];
            sh_d       = {sh_q[191:0], 8'h00};
            tx_cnt_d   = tx_cnt_q + 5'd1;
          end
        end
      end
`endif
      default: state_d = S_RECV;
    endcase

    // Outputs are registered copies of what the next state wants
    in_ready_d    = (state_d == S_RECV);
    busy_d        = (state_d != S_RECV);
    start_d       = (state_d == S_START);
    mem_own_d     = !((state_d == S_START) ||
                      (state_d == S_WAIT));
    mem_wren_d    = 1'b0;
    mem_address_d = 2'd0;
    mem_data_d    = '0;
`ifdef MATRIX_LOADER_READBACK_EN
    out_valid_d   = (state_d == S_TX);
`endif

    unique case (state_d)
      S_WR0: begin
        mem_wren_d    = 1'b1;
        mem_address_d = 2'd0;
        mem_data_d    = {184'b0, opcode_d, msize_d};
      end
      S_WR1: begin
        mem_wren_d    = 1'b1;
        mem_address_d = 2'd1;
        mem_data_d    = a_d;
      end
      S_WR2: begin
        mem_wren_d    = 1'b1;
        mem_address_d = 2'd2;
        mem_data_d    = b_d;
      end
`ifdef MATRIX_LOADER_READBACK_EN
      S_RD: begin
        mem_address_d = 2'd3;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_coprocessor or posedge rst) begin
    if (rst) begin
      state_q       <= S_RECV;
      cnt_q         <= '0;
      msize_q       <= '0;
      opcode_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      ovf_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_own_q     <= 1'b1;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      msize_q       <= msize_d;
      opcode_q      <= opcode_d;
      a_q           <= a_d;
      b_q           <= b_d;
      ovf_q         <= ovf_d;
      in_ready_q    <= in_ready_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      mem_own_q     <= mem_own_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
    end
  end

`ifdef MATRIX_LOADER_READBACK_EN
  always_ff @(posedge clk_coprocessor or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      sh_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`else
  logic unused_rb;
  assign unused_rb = ^{bus.mem_q, bus.out_ready,
                       RD_LAT != 32'd0};

  assign bus.out_valid = 1'b0;
  assign bus.out_data  = '0;
`endif

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_own     = mem_own_q;
  assign bus.start       = start_q;
  assign bus.ovf_flag    = ovf_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Host-side front end of the matrix coprocessor memory. Accepts a byte stream from the HPS bridge (header, matrix A, matrix B), packs it into the three 200-bit words the control unit fetches, writes them to the shared memory at addresses 0–2, and pulses `start`. It then waits for the control unit's `ready` pulse and, optionally, reads the result word at address 3 back and streams it to the host.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles, from `mem_address` stable to `mem_q` valid.
- `clk_coprocessor` input 1: clock, the same divided clock as the control unit.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: host byte valid.
- `in_data` input 8: host byte.
- `in_ready` output 1: loader accepts a byte when `in_valid && in_ready`.
- `out_valid` output 1: readback byte valid.
- `out_data` output 8: readback byte.
- `out_ready` input 1: host accepts a readback byte.
- `mem_address` output 2: memory address.
- `mem_data` output 200: memory write data.
- `mem_wren` output 1: memory write enable.
- `mem_q` input 200: memory read data.
- `mem_own` output 1: top-level mux select; 1 = loader drives the memory port, 0 = control unit drives it.
- `start` output 1: one-cycle start pulse to the control unit.
- `ready` input 1: control unit completion pulse.
- `overflow` input 1: control unit overflow, sampled together with `ready`.
- `ovf_flag` output 1: overflow latched at the last `ready`.
- `busy` output 1: high in every state except RECV.

## Operation
- **Frame:** 52 bytes in this order.
  - Byte 0: msize; bits [1:0] used (0 = 2x2 … 3 = 5x5).
  - Byte 1: opcode; bits [2:0] used.
  - Bytes 2–26: matrix A.
  - Bytes 27–51: matrix B.
- **Matrix packing:** row-major, MSB-first. Element (r,c) lands at bits [199−8(5r+c) −: 8]. Matrices are always 25 bytes; unused elements are sent as zeros.
- **Instruction word:** `{184'b0, opcode_byte, msize_byte}`. opcode sits in [15:8], msize in [7:0].
- **State machine:** RECV → WR0 → WR1 → WR2 → START → WAIT → RD → TX → RECV.
  - **RECV:** `in_ready`=1. A 6-bit byte counter advances on each handshake. The handshake on byte 51 moves the FSM to WR0.
  - **WR0 / WR1 / WR2:** one cycle each. `mem_wren`=1, `mem_address`=0/1/2, `mem_data`=instruction/A/B.
  - **START:** `start`=1 for exactly one cycle, `mem_wren`=0, `mem_own`=0.
  - **WAIT:** `mem_own`=0. On a cycle with `ready`=1, latch `overflow` into `ovf_flag` and go to RD, or to RECV if readback is compiled out. No timeout.
  - **RD:** `mem_own`=1, `mem_address`=3, `mem_wren`=0. After RD_LAT cycles, capture `mem_q` into a 200-bit transmit shift register, then go to TX.
  - **TX:** 26 bytes. Byte 0 is the status byte `{7'b0, ovf_flag}`. Bytes 1–25 are the result, MSB-first. `out_data` advances only on `out_valid && out_ready`. The last handshake returns the FSM to RECV.
- `ready` outside WAIT is ignored.
- `in_valid` outside RECV is ignored; `in_ready`=0 there.
- `mem_own`=1 in all states except START and WAIT.

## Timing
- **Reset values:**
  - Outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `mem_address`=0, `mem_data`=0, `mem_wren`=0, `mem_own`=1, `start`=0, `ovf_flag`=0, `busy`=0.
  - FSM: RECV, counter=0.
  - `in_ready` rises on the first clock edge after reset release.
- **Write phase:** byte 51 accepted at edge N → WR0 at N+1, WR1 at N+2, WR2 at N+3, `start` high during N+4 only.
- **Readback latency:** `ready` sampled at edge R → `mem_address`=3 from R+1 → `mem_q` captured at R+1+RD_LAT → `out_valid`=1 from the next cycle.
- **Backpressure:** `out_data` and `out_valid` hold stable while `out_ready`=0.
- **Reset mid-operation:** any state returns to RECV and the partial frame is discarded. `mem_wren` and `start` drop immediately (asynchronous).
- **Handshake timing:** `in_ready` and `out_valid` are registered; there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- **`MATRIX_LOADER_READBACK_EN` defined:** RD and TX states exist as described above.
- **Undefined:**
  - RD and TX are removed; WAIT goes directly to RECV on `ready`.
  - `out_valid` and `out_data` are tied to 0.
  - `ovf_flag` is still latched.
  - `mem_own` returns to 1 the cycle after `ready`.

## Test plan
- **Reset values:** hold `rst` for 3 cycles → all outputs at reset values; `in_ready`=1 one edge after release.
- **Write phase:** send 0x03, 0x00, 25×0x01, 25×0x02 →
  - address 0 written with data 0x…0003, then address 1 with 25×0x01, then address 2 with 25×0x02, on consecutive cycles;
  - `start` high exactly one cycle after the WR2 cycle;
  - `mem_own`=0 until `ready`.
- **Readback:** memory model holds 25×0x03 at address 3; pulse `ready` with `overflow`=0 → `out_data` sequence is 0x00 followed by 25×0x03; FSM returns to RECV and `in_ready`=1.
- **Backpressure:** drop `out_ready` for 5 cycles after byte 10 → byte 10 held stable, no byte lost or duplicated. `in_valid`=1 with 0xFF during TX → not accepted.
- **Overflow:** pulse `ready` with `overflow`=1 → status byte 0x01 and `ovf_flag`=1; the next run with `overflow`=0 clears `ovf_flag` to 0.
- **Reset mid-frame:** assert `rst` after 30 bytes → no `mem_wren` pulse; a subsequent full frame writes correct words. With the macro undefined → `out_valid` never asserts.
